// File: rtl/pbus_seq.sv
// -----------------------------------------------------------------------------
// pbus_seq -- P-bus line sequencer
//
// Purpose:
//   Free-running phase counter that splits every video line into 32 base slots
//   (B = PHASE >> (CNT_W-5)). From B it generates the P-bus strobes and loads
//   PBUS_OUT with the address or palette word belonging to each bus slot. All
//   outputs are registered. They are decoded from the *next* phase value, so
//   each output is valid in the same cycle as the PHASE value it describes.
//
// Parameter:
//   CNT_W        phase counter width (>= 5); line = 2^CNT_W clocks
//
// Configuration macro:
//   PBUS_SEQ_L0_EN  defined   -> L0 function present (slot B=3, nVCS, L0_DATA)
//                   undefined -> slot B=3 absent, nVCS = 1, L0_DATA = 0
//
// Ports:
//   CLK_24M        in   sole clock, rising edge
//   nRESET         in   asynchronous active-low reset
//   RESYNC         in   synchronous phase restart (next PHASE = 0)
//   FIX_ROM_ADDR   in   [16:0] fix layer ROM address
//   FIX_PAL        in   [3:0]  fix layer palette
//   SPR_ROM_ADDR   in   [24:0] sprite ROM address
//   SPR_PAL        in   [7:0]  sprite palette
//   SPR_XPOS       in   [7:0]  sprite X position
//   L0_ROM_ADDR    in   [15:0] L0 ROM address
//   PBUS_IN        in   [7:0]  PBUS[23:16] readback
//   PBUS_OUT       out  [23:0] P-bus drive value
//   PBUS_OE_U      out  drive enable for PBUS[23:16]
//   PCK1, PCK2     out  P-bus latch clocks
//   LOAD, S1H1, S2H1 out  line timing strobes
//   nVCS           out  L0 ROM chip select (active low)
//   L0_DATA        out  [7:0] captured L0 readback byte
//   PHASE          out  [CNT_W-1:0] current phase
// -----------------------------------------------------------------------------
module pbus_seq #(
  parameter int CNT_W = 5
) (
  input  logic             CLK_24M,
  input  logic             nRESET,
  input  logic             RESYNC,
  input  logic [16:0]      FIX_ROM_ADDR,
  input  logic [3:0]       FIX_PAL,
  input  logic [24:0]      SPR_ROM_ADDR,
  input  logic [7:0]       SPR_PAL,
  input  logic [7:0]       SPR_XPOS,
  input  logic [15:0]      L0_ROM_ADDR,
  input  logic [7:0]       PBUS_IN,
  output logic [23:0]      PBUS_OUT,
  output logic             PBUS_OE_U,
  output logic             PCK1,
  output logic             PCK2,
  output logic             LOAD,
  output logic             S1H1,
  output logic             S2H1,
  output logic             nVCS,
  output logic [7:0]       L0_DATA,
  output logic [CNT_W-1:0] PHASE
);

  // Number of low phase bits below the base slot.
  localparam int SUB_W     = CNT_W - 5;
  localparam int NUM_SLOTS = 6;
  // Base slots that load PBUS_OUT; index 1 (B=3) is the L0 slot.
  localparam logic [4:0] SLOT_B [NUM_SLOTS] = '{5'd0, 5'd3, 5'd13, 5'd16, 5'd19, 5'd29};

  logic [CNT_W-1:0]     phase_reg, phase_next;
  logic [4:0]           b_reg, b_next;
  logic                 first_next;   // next phase is the first phase of its slot
  logic                 last_reg;     // current phase is the last phase of its slot
  logic [NUM_SLOTS-1:0] slot_hit;

  logic [23:0] pbus_reg, pbus_next;
  logic        oe_reg, oe_next;
  logic        pck1_reg, pck1_next;
  logic        pck2_reg, pck2_next;
  logic        load_reg, load_next;
  logic        s1h1_reg, s1h1_next;
  logic        s2h1_reg, s2h1_next;

  // RESYNC wins over the increment, including at the wrap point.
  assign phase_next = RESYNC ? '0 : phase_reg + CNT_W'(1);
  assign b_next     = phase_next[CNT_W-1 -: 5];
  assign b_reg      = phase_reg[CNT_W-1 -: 5];

  generate
    if (SUB_W == 0) begin : g_nosub
      assign first_next = 1'b1;
      assign last_reg   = 1'b1;
    end else begin : g_sub
      assign first_next = (phase_next[SUB_W-1:0] == '0);
      assign last_reg   = &phase_reg[SUB_W-1:0];
    end
  endgenerate

  // Slot entry strobes. A restart lands on slot 0 directly, so slots
  // jumped over never see their entry phase and never load.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign slot_hit[gi] = first_next && (b_next == SLOT_B[gi]);
    end
  endgenerate

  // Strobe decode of the next slot.
  always_comb begin
    pck1_next = (b_next <= 5'd1);
    pck2_next = (b_next == 5'd16) || (b_next == 5'd17);
    load_next = ((b_next >= 5'd13) && (b_next <= 5'd16)) ||
                (b_next >= 5'd29) || (b_next == 5'd0);
    s1h1_next = b_next[3];
    s2h1_next = ~b_next[4];
  end

  // Bus word selection; the slots are mutually exclusive, so the order of
  // these tests does not matter.
  always_comb begin
    pbus_next = pbus_reg;
    oe_next   = oe_reg;
    if (slot_hit[0]) begin
      pbus_next = {SPR_ROM_ADDR[24:21], SPR_ROM_ADDR[3:0], SPR_ROM_ADDR[20:5]};
      oe_next   = 1'b1;
    end
`ifdef PBUS_SEQ_L0_EN
    if (slot_hit[1]) begin
      pbus_next = {8'h00, L0_ROM_ADDR};
      oe_next   = 1'b0;   // upper byte is read back from the L0 ROM
    end
`endif
    if (slot_hit[2]) begin
      pbus_next = {SPR_PAL, SPR_XPOS, 8'h00};
      oe_next   = 1'b1;
    end
    if (slot_hit[3]) begin
      pbus_next = {8'h00, FIX_ROM_ADDR[4], FIX_ROM_ADDR[2:0], FIX_ROM_ADDR[16:5]};
      oe_next   = 1'b1;
    end
    if (slot_hit[4]) begin
      pbus_next = 24'hFF0000;
      oe_next   = 1'b1;
    end
    if (slot_hit[5]) begin
      pbus_next = {4'h0, FIX_PAL, 16'h0000};
      oe_next   = 1'b1;
    end
  end

  // Reset parks the counter on the last phase so the first edge after
  // release lands on phase 0 and runs the full slot-0 decode.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      phase_reg <= '1;
      pbus_reg  <= '0;
      oe_reg    <= 1'b1;
      pck1_reg  <= 1'b0;
      pck2_reg  <= 1'b0;
      load_reg  <= 1'b0;
      s1h1_reg  <= 1'b0;
      s2h1_reg  <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      pbus_reg  <= pbus_next;
      oe_reg    <= oe_next;
      pck1_reg  <= pck1_next;
      pck2_reg  <= pck2_next;
      load_reg  <= load_next;
      s1h1_reg  <= s1h1_next;
      s2h1_reg  <= s2h1_next;
    end
  end

`ifdef PBUS_SEQ_L0_EN
  logic       nvcs_reg, nvcs_next;
  logic [7:0] l0_reg;

  assign nvcs_next = !((b_next >= 5'd3) && (b_next <= 5'd12));

  // L0 byte is taken on the edge that leaves the last phase of slot 12,
  // whether that edge increments or restarts the line.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      nvcs_reg <= 1'b1;
      l0_reg   <= '0;
    end else begin
      nvcs_reg <= nvcs_next;
      if ((b_reg == 5'd12) && last_reg) begin
        l0_reg <= PBUS_IN;
      end
    end
  end

  assign nVCS    = nvcs_reg;
  assign L0_DATA = l0_reg;
`else
  assign nVCS    = 1'b1;
  assign L0_DATA = '0;

  logic unused_l0;
  assign unused_l0 = ^{L0_ROM_ADDR, PBUS_IN, slot_hit[1], b_reg, last_reg};
`endif

  // Bit 3 of the fix address is not part of any bus word.
  logic unused_fix;
  assign unused_fix = FIX_ROM_ADDR[3];

  assign PHASE     = phase_reg;
  assign PBUS_OUT  = pbus_reg;
  assign PBUS_OE_U = oe_reg;
  assign PCK1      = pck1_reg;
  assign PCK2      = pck2_reg;
  assign LOAD      = load_reg;
  assign S1H1      = s1h1_reg;
  assign S2H1      = s2h1_reg;

endmodule
